// File: rtl/instr_fetch_unit.sv
// Multi-cycle instruction fetch stage: owns the PC, fetches over req/ack into IR,
// and hands decoded fields downstream over valid/ready with branch/jump redirects.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] PC_STEP  = 32'd4
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        pc_load,
  input  logic [31:0] pc_load_addr,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [5:0]  opcode,
  output logic [4:0]  rs,
  output logic [4:0]  rt,
  output logic [4:0]  rd,
  output logic [5:0]  funct,
  output logic [15:0] imm16,
  output logic [31:0] pc_out
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  state_t      state_r;
  logic [31:0] pc_r;
  logic [31:0] ir_r;
  logic [31:0] pc_out_r;
  logic [31:0] tgt_r;
  logic        flush_r;
  logic        req_r;
  logic        valid_r;
  logic [31:0] redirect_s;

  // Redirect targets are always word aligned.
  assign redirect_s = {pc_load_addr[31:2], 2'b00};

  // Fetch FSM: PC, IR, pending-redirect bookkeeping and registered handshake outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= S_IDLE;
      pc_r     <= RESET_PC;
      ir_r     <= 32'h0000_0000;
      pc_out_r <= RESET_PC;
      tgt_r    <= 32'h0000_0000;
      flush_r  <= 1'b0;
      req_r    <= 1'b0;
      valid_r  <= 1'b0;
    end else begin
      case (state_r)
        S_IDLE: begin
          state_r <= S_REQ;
          req_r   <= 1'b1;
          valid_r <= 1'b0;
        end
        S_REQ: begin
          if (imem_ack) begin
            if (pc_load) begin
              // A same-cycle redirect beats any stored one; the word is stale.
              pc_r    <= redirect_s;
              flush_r <= 1'b0;
            end else if (flush_r) begin
              pc_r    <= tgt_r;
              flush_r <= 1'b0;
            end else begin
              ir_r     <= imem_rdata;
              pc_out_r <= pc_r;
              state_r  <= S_HOLD;
              req_r    <= 1'b0;
              valid_r  <= 1'b1;
            end
          end else if (pc_load) begin
            // Address must stay stable until ack, so park the target for later.
            flush_r <= 1'b1;
            tgt_r   <= redirect_s;
          end else begin
            flush_r <= flush_r;
          end
        end
        S_HOLD: begin
          if (pc_load) begin
            pc_r    <= redirect_s;
            state_r <= S_REQ;
            req_r   <= 1'b1;
            valid_r <= 1'b0;
          end else if (instr_ready) begin
            pc_r    <= pc_r + PC_STEP;
            state_r <= S_REQ;
            req_r   <= 1'b1;
            valid_r <= 1'b0;
          end else begin
            state_r <= S_HOLD;
          end
        end
        default: begin
          state_r <= S_IDLE;
          req_r   <= 1'b0;
          valid_r <= 1'b0;
          flush_r <= 1'b0;
        end
      endcase
    end
  end

  assign imem_req    = req_r;
  assign imem_addr   = pc_r;
  assign instr_valid = valid_r;
  assign instr       = ir_r;
  assign opcode      = ir_r[31:26];
  assign rs          = ir_r[25:21];
  assign rt          = ir_r[20:16];
  assign rd          = ir_r[15:11];
  assign funct       = ir_r[5:0];
  assign imm16       = ir_r[15:0];
  assign pc_out      = pc_out_r;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed self-checking bench for instr_fetch_unit; a second instance
// with RESET_PC at the top of the address space covers PC wrap.
module tb_instr_fetch_unit;

  logic        clk;
  logic        rst_n;
  logic        imem_req, imem_ack, pc_load, instr_valid, instr_ready;
  logic [31:0] imem_addr, imem_rdata, pc_load_addr, instr, pc_out;
  logic [5:0]  opcode, funct;
  logic [4:0]  rs, rt, rd;
  logic [15:0] imm16;

  logic        w_req, w_ack, w_pc_load, w_valid, w_ready;
  logic [31:0] w_addr, w_rdata, w_pc_load_addr, w_instr, w_pc_out;
  logic [5:0]  w_opcode, w_funct;
  logic [4:0]  w_rs, w_rt, w_rd;
  logic [15:0] w_imm16;

  int checks;
  int errors;

  instr_fetch_unit dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .pc_load(pc_load), .pc_load_addr(pc_load_addr),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
    .opcode(opcode), .rs(rs), .rt(rt), .rd(rd), .funct(funct), .imm16(imm16),
    .pc_out(pc_out)
  );

  instr_fetch_unit #(.RESET_PC(32'hFFFF_FFFC), .PC_STEP(32'd4)) u_wrap (
    .clk(clk), .rst_n(rst_n),
    .imem_req(w_req), .imem_addr(w_addr), .imem_ack(w_ack), .imem_rdata(w_rdata),
    .pc_load(w_pc_load), .pc_load_addr(w_pc_load_addr),
    .instr_valid(w_valid), .instr_ready(w_ready), .instr(w_instr),
    .opcode(w_opcode), .rs(w_rs), .rt(w_rt), .rd(w_rd), .funct(w_funct), .imm16(w_imm16),
    .pc_out(w_pc_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reset both instances and return at the first negedge with imem_req high.
  task automatic apply_reset();
    rst_n = 1'b0;
    imem_ack = 1'b0; imem_rdata = 32'h0; pc_load = 1'b0; pc_load_addr = 32'h0; instr_ready = 1'b0;
    w_ack = 1'b0; w_rdata = 32'h0; w_pc_load = 1'b0; w_pc_load_addr = 32'h0; w_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    imem_ack = 1'b0; imem_rdata = 32'h0; pc_load = 1'b0; pc_load_addr = 32'h0; instr_ready = 1'b0;
    w_ack = 1'b0; w_rdata = 32'h0; w_pc_load = 1'b0; w_pc_load_addr = 32'h0; w_ready = 1'b0;
    #3;
    @(negedge clk);
    checks++;
    if ({imem_req, instr_valid} !== 2'b00) begin
      errors++; $display("FAIL reset_hs: got req/valid %b%b want 00", imem_req, instr_valid);
    end
    checks++;
    if (imem_addr !== 32'h0 || pc_out !== 32'h0 || instr !== 32'h0) begin
      errors++; $display("FAIL reset_regs: got addr %h pc_out %h instr %h want 0", imem_addr, pc_out, instr);
    end
    checks++;
    if ({opcode, rs, rt, rd, funct, imm16} !== 43'h0) begin
      errors++; $display("FAIL reset_fields: got %h want 0", {opcode, rs, rt, rd, funct, imm16});
    end
    rst_n = 1'b1;
    #1;
    checks++;
    if (imem_req !== 1'b0) begin
      errors++; $display("FAIL idle_req: got %b want 0", imem_req);
    end
    @(negedge clk);
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
      errors++; $display("FAIL first_req: got req %b addr %h want 1 0", imem_req, imem_addr);
    end
  endtask

  task automatic test_single_fetch();
    apply_reset();
    @(negedge clk);
    checks++;
    if (imem_req !== 1'b1 || instr_valid !== 1'b0 || imem_addr !== 32'h0) begin
      errors++; $display("FAIL wait_ack: got req %b valid %b addr %h want 1 0 0", imem_req, instr_valid, imem_addr);
    end
    @(negedge clk);
    imem_ack = 1'b1; imem_rdata = 32'h8C22_FFF0;
    @(negedge clk);
    imem_ack = 1'b0;
    checks++;
    if (instr_valid !== 1'b1 || imem_req !== 1'b0) begin
      errors++; $display("FAIL fetch_valid: got valid %b req %b want 1 0", instr_valid, imem_req);
    end
    checks++;
    if (opcode !== 6'h23 || rs !== 5'd1 || rt !== 5'd2 || rd !== 5'd31 || funct !== 6'h30) begin
      errors++; $display("FAIL fetch_fields: got op %h rs %0d rt %0d rd %0d funct %h want 23 1 2 31 30",
                         opcode, rs, rt, rd, funct);
    end
    checks++;
    if (imm16 !== 16'hFFF0 || pc_out !== 32'h0 || instr !== 32'h8C22_FFF0) begin
      errors++; $display("FAIL fetch_imm: got imm %h pc_out %h instr %h want fff0 0 8c22fff0", imm16, pc_out, instr);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] data [3];
    data[0] = 32'h1111_AAAA; data[1] = 32'h2222_BBBB; data[2] = 32'h3333_CCCC;
    apply_reset();
    instr_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (imem_req !== 1'b1 || instr_valid !== 1'b0 || imem_addr !== 32'(4 * i)) begin
        errors++; $display("FAIL b2b_req%0d: got req %b valid %b addr %h want 1 0 %h",
                           i, imem_req, instr_valid, imem_addr, 32'(4 * i));
      end
      imem_ack = 1'b1; imem_rdata = data[i];
      @(negedge clk);
      imem_ack = 1'b0;
      checks++;
      if (instr_valid !== 1'b1 || instr !== data[i] || pc_out !== 32'(4 * i)) begin
        errors++; $display("FAIL b2b_ir%0d: got valid %b instr %h pc_out %h want 1 %h %h",
                           i, instr_valid, instr, pc_out, data[i], 32'(4 * i));
      end
      @(negedge clk);
    end
    instr_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    apply_reset();
    imem_ack = 1'b1; imem_rdata = 32'h0123_4567;
    @(negedge clk);
    imem_ack = 1'b0;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (instr_valid !== 1'b1 || imem_req !== 1'b0 || instr !== 32'h0123_4567 ||
          imm16 !== 16'h4567 || imem_addr !== 32'h0) begin
        errors++; $display("FAIL stall%0d: got valid %b req %b instr %h addr %h want 1 0 01234567 0",
                           i, instr_valid, imem_req, instr, imem_addr);
      end
      imem_ack = (i == 2);
      @(negedge clk);
    end
    imem_ack = 1'b0;
    instr_ready = 1'b1;
    @(negedge clk);
    instr_ready = 1'b0;
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h4 || instr_valid !== 1'b0) begin
      errors++; $display("FAIL stall_release: got req %b addr %h valid %b want 1 4 0", imem_req, imem_addr, instr_valid);
    end
  endtask

  task automatic test_redirect_fetch();
    apply_reset();
    pc_load = 1'b1; pc_load_addr = 32'h0000_0103;
    @(negedge clk);
    pc_load = 1'b0;
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
      errors++; $display("FAIL redir_hold_addr: got req %b addr %h want 1 0", imem_req, imem_addr);
    end
    @(negedge clk);
    @(negedge clk);
    imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    imem_ack = 1'b0;
    checks++;
    if (instr_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h0000_0100) begin
      errors++; $display("FAIL redir_flush: got valid %b req %b addr %h want 0 1 100", instr_valid, imem_req, imem_addr);
    end
    imem_ack = 1'b1; imem_rdata = 32'h0BAD_F00D;
    @(negedge clk);
    imem_ack = 1'b0;
    checks++;
    if (instr_valid !== 1'b1 || instr !== 32'h0BAD_F00D || pc_out !== 32'h0000_0100) begin
      errors++; $display("FAIL redir_latch: got valid %b instr %h pc_out %h want 1 0badf00d 100", instr_valid, instr, pc_out);
    end
  endtask

  task automatic test_redirect_hold();
    apply_reset();
    // Same-cycle pc_load and ack: data dropped, PC jumps.
    pc_load = 1'b1; pc_load_addr = 32'h0000_0040; imem_ack = 1'b1; imem_rdata = 32'hFFFF_FFFF;
    @(negedge clk);
    pc_load = 1'b0; imem_ack = 1'b0;
    checks++;
    if (instr_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h40) begin
      errors++; $display("FAIL ack_redir: got valid %b req %b addr %h want 0 1 40", instr_valid, imem_req, imem_addr);
    end
    imem_ack = 1'b1; imem_rdata = 32'h2000_0001;
    @(negedge clk);
    imem_ack = 1'b0;
    checks++;
    if (instr_valid !== 1'b1 || pc_out !== 32'h40) begin
      errors++; $display("FAIL hold_at40: got valid %b pc_out %h want 1 40", instr_valid, pc_out);
    end
    instr_ready = 1'b1; pc_load = 1'b1; pc_load_addr = 32'h0000_0200;
    @(negedge clk);
    instr_ready = 1'b0; pc_load = 1'b0;
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h200 || instr_valid !== 1'b0) begin
      errors++; $display("FAIL hold_redir: got req %b addr %h valid %b want 1 200 0", imem_req, imem_addr, instr_valid);
    end
  endtask

  task automatic test_wrap_reset();
    apply_reset();
    checks++;
    if (w_req !== 1'b1 || w_addr !== 32'hFFFF_FFFC) begin
      errors++; $display("FAIL wrap_start: got req %b addr %h want 1 fffffffc", w_req, w_addr);
    end
    w_ack = 1'b1; w_rdata = 32'hCAFE_0001;
    @(negedge clk);
    w_ack = 1'b0;
    checks++;
    if (w_valid !== 1'b1 || w_pc_out !== 32'hFFFF_FFFC || w_instr !== 32'hCAFE_0001) begin
      errors++; $display("FAIL wrap_fetch: got valid %b pc_out %h instr %h want 1 fffffffc cafe0001",
                         w_valid, w_pc_out, w_instr);
    end
    w_ready = 1'b1;
    @(negedge clk);
    w_ready = 1'b0;
    checks++;
    if (w_req !== 1'b1 || w_addr !== 32'h0) begin
      errors++; $display("FAIL wrap_addr: got req %b addr %h want 1 0", w_req, w_addr);
    end
    // Asynchronous reset in the middle of S_REQ, away from any clock edge.
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (w_req !== 1'b0 || w_valid !== 1'b0 || w_addr !== 32'hFFFF_FFFC || w_pc_out !== 32'hFFFF_FFFC) begin
      errors++; $display("FAIL async_rst: got req %b valid %b addr %h pc_out %h want 0 0 fffffffc fffffffc",
                         w_req, w_valid, w_addr, w_pc_out);
    end
    w_ack = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    w_ack = 1'b0;
    checks++;
    if (w_valid !== 1'b0 || w_req !== 1'b1 || w_addr !== 32'hFFFF_FFFC) begin
      errors++; $display("FAIL post_rst: got valid %b req %b addr %h want 0 1 fffffffc", w_valid, w_req, w_addr);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_single_fetch();
    test_back_to_back();
    test_backpressure();
    test_redirect_fetch();
    test_redirect_hold();
    test_wrap_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Multi-cycle instruction fetch stage that sits directly upstream of the decode/sign-extension path.
- Holds the PC and fetches one 32-bit word from instruction memory over a req/ack handshake, latching it into an instruction register (IR).
- Presents the decoded fields, including imm16, which feeds the 16-to-32 sign extender, to the downstream stage over a valid/ready handshake.
- Accepts PC redirects from the branch/jump logic.

Parameters:
- RESET_PC, 32'h0000_0000: PC value loaded on reset; bits [1:0] must be 0.
- PC_STEP, 4: byte increment applied to the PC per consumed instruction.

Ports:
- clk, input, 1: single clock; all state updates on the rising edge.
- rst_n, input, 1: asynchronous, active-low reset.
- imem_req, output, 1: fetch request to instruction memory.
- imem_addr, output, 32: fetch address; always equals pc.
- imem_ack, input, 1: single-cycle pulse; imem_rdata is valid in the same cycle.
- imem_rdata, input, 32: fetched instruction word.
- pc_load, input, 1: redirect request from branch/jump logic.
- pc_load_addr, input, 32: redirect target; bits [1:0] are ignored and forced to 0.
- instr_valid, output, 1: IR holds an instruction not yet consumed.
- instr_ready, input, 1: downstream accepts the instruction.
- instr, output, 32: IR contents.
- opcode, output, 6: IR[31:26].
- rs, output, 5: IR[25:21].
- rt, output, 5: IR[20:16].
- rd, output, 5: IR[15:11].
- funct, output, 6: IR[5:0].
- imm16, output, 16: IR[15:0], sent to the sign extender.
- pc_out, output, 32: address of the instruction currently in IR.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - state=S_IDLE, pc=RESET_PC, IR=0, flush=0.
  - imem_req=0, instr_valid=0, pc_out=RESET_PC, all field outputs 0.
- States: S_IDLE, S_REQ, S_HOLD. Outputs decode from registered state.
  - imem_req=1 only in S_REQ.
  - instr_valid=1 only in S_HOLD.
- S_IDLE: unconditionally go to S_REQ on the first edge after reset release.
- S_REQ:
  - imem_addr=pc, held stable until ack.
  - Without ack: stay in S_REQ. If pc_load=1 here, set flush=1 and store the target into pc_next_tgt. A later pc_load overwrites the stored target.
  - On ack with flush=0 and pc_load=0: IR<=imem_rdata, pc_out<=pc, go to S_HOLD.
  - On ack with flush=1 or pc_load=1: discard imem_rdata, pc<=target, flush<=0, stay in S_REQ. A same-cycle pc_load takes priority over the stored target. The next request issues with the new address on the following cycle; req stays high.
- S_HOLD:
  - Fields are driven combinationally from IR and are stable while instr_valid=1.
  - instr_ready=1 and pc_load=0: pc<=pc+PC_STEP, go to S_REQ.
  - pc_load=1, with or without instr_ready: instruction counts as consumed, pc<=pc_load_addr&~3, go to S_REQ.
  - Neither: hold IR and pc, stay in S_HOLD.
- Latency:
  - First imem_req rises 1 cycle after reset release.
  - instr_valid rises 1 cycle after the accepted ack.
  - Minimum throughput is one instruction per 2 cycles (ack in the first S_REQ cycle, ready in the first S_HOLD cycle).
- Arithmetic: pc increments modulo 2^32, so 32'hFFFF_FFFC+4 wraps to 32'h0000_0000 with no flag.
- Ack outside S_REQ: ignored; no state change.
- Reset mid-fetch: all state returns to reset values immediately. Any in-flight ack after reset is ignored because imem_req=0 in S_IDLE.

Test Plan:
- Reset then memory acks 2 cycles after req with rdata 32'h8C22_FFF0 -> imem_addr=0. instr_valid rises 1 cycle after the ack. opcode=6'h23, rs=1, rt=2, imm16=16'hFFF0, pc_out=0.
- Back-to-back: memory acks immediately, instr_ready tied high, rdata sequence A,B,C -> imem_addr sequence 0,4,8. instr_valid every other cycle. IR matches A,B,C in order.
- Backpressure: instr_ready=0 for 5 cycles in S_HOLD -> instr and fields stable, imem_req=0, pc unchanged. Releasing ready gives next imem_addr=pc+4.
- Redirect during an outstanding fetch: pc_load=1 with pc_load_addr=32'h0000_0103 while waiting for ack; ack 3 cycles later with 32'hDEAD_BEEF -> instr_valid stays 0. Next imem_addr=32'h0000_0100. Its rdata is latched normally.
- Redirect in S_HOLD coinciding with instr_ready: pc=32'h40, pc_load_addr=32'h200 -> next imem_addr=32'h200, not 32'h44.
- Wrap and reset: RESET_PC=32'hFFFF_FFFC; fetch and consume once -> next imem_addr=0. Assert rst_n=0 mid-S_REQ -> imem_req and instr_valid drop asynchronously and pc=RESET_PC.
